// File: rtl/absmem_wlog.sv
// rtl/absmem_wlog.sv - one side's coalescing write log with read and cross-side lookup ports
module absmem_wlog #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wen,
    input  logic [AW-1:0]              waddr,
    input  logic [DW-1:0]              wdata,
    input  logic [AW-1:0]              raddr,
    output logic                       rhit,
    output logic [DW-1:0]              rdata,
    input  logic [DEPTH-1:0][AW-1:0]   xaddr,
    output logic [DEPTH-1:0]           xhit,
    output logic [DEPTH-1:0][DW-1:0]   xdata,
    output logic [DEPTH-1:0]           ent_valid,
    output logic [DEPTH-1:0][AW-1:0]   ent_addr,
    output logic [DEPTH-1:0][DW-1:0]   ent_data,
    output logic [CW-1:0]              cnt,
    output logic                       full,
    output logic                       whit
);

    logic [DEPTH-1:0]         valid_q;
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [CW-1:0]            cnt_q;
    logic [DEPTH-1:0]         whit_vec;

    assign full      = (cnt_q == CW'(DEPTH));
    assign cnt       = cnt_q;
    assign ent_valid = valid_q;
    assign ent_addr  = addr_q;
    assign ent_data  = data_q;

    always_comb begin
        whit_vec = '0;
        rhit     = 1'b0;
        rdata    = '0;
        xhit     = '0;
        xdata    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            whit_vec[i] = valid_q[i] && (addr_q[i] == waddr);
            if (valid_q[i] && (addr_q[i] == raddr)) begin
                rhit  = 1'b1;
                rdata = data_q[i];
            end
        end
        // Addresses are unique within a log, so at most one entry hits per lookup.
        for (int j = 0; j < DEPTH; j++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (addr_q[i] == xaddr[j])) begin
                    xhit[j]  = 1'b1;
                    xdata[j] = data_q[i];
                end
            end
        end
    end

    assign whit = |whit_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else if (wen) begin
            if (whit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (whit_vec[i]) data_q[i] <= wdata;
                end
            end else if (!full) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (cnt_q == CW'(i)) begin
                        valid_q[i] <= 1'b1;
                        addr_q[i]  <= waddr;
                        data_q[i]  <= wdata;
                    end
                end
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/absmem_wlog_multi.sv
// rtl/absmem_wlog_multi.sv - dual write-log abstract memory over a shared symbolic base array
module absmem_wlog_multi #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int TTS   = 256,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue,
    input  logic          compare,
    input  logic [AW-1:0] vlg_raddr,
    input  logic          vlg_ren,
    output logic [DW-1:0] vlg_rdata,
    input  logic [AW-1:0] vlg_waddr,
    input  logic [DW-1:0] vlg_wdata,
    input  logic          vlg_wen,
    input  logic [DW-1:0] vlg_r_rand_input,
    input  logic [AW-1:0] ila_raddr,
    input  logic          ila_ren,
    output logic [DW-1:0] ila_rdata,
    input  logic [AW-1:0] ila_waddr,
    input  logic [DW-1:0] ila_wdata,
    input  logic          ila_wen,
    input  logic [DW-1:0] ila_r_rand_input,
    output logic          equal,
    output logic          overflow,
    output logic [CW-1:0] vlg_cnt,
    output logic [CW-1:0] ila_cnt
);

    logic armed_q;
    logic overflow_q;
    logic [DW-1:0] mem [TTS];

    // The base array is a free symbolic value: it holds whatever it starts with.
    always_ff @(posedge clk) mem <= mem;

    logic vlg_ren_real, vlg_wen_real, ila_ren_real, ila_wen_real;
    assign vlg_ren_real = vlg_ren & armed_q & ~compare;
    assign vlg_wen_real = vlg_wen & armed_q & ~compare;
    assign ila_ren_real = ila_ren & armed_q & ~compare;
    assign ila_wen_real = ila_wen & armed_q & ~compare;

    logic                     vlg_rhit, ila_rhit, vlg_full, ila_full, vlg_whit, ila_whit;
    logic [DW-1:0]            vlg_hdata, ila_hdata;
    logic [DEPTH-1:0]         vlg_valid, ila_valid, vlg_xhit, ila_xhit;
    logic [DEPTH-1:0][AW-1:0] vlg_addr, ila_addr;
    logic [DEPTH-1:0][DW-1:0] vlg_data, ila_data, vlg_xdata, ila_xdata;

    absmem_wlog #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW)) u_vlg (
        .clk(clk), .rst_n(rst_n),
        .wen(vlg_wen_real), .waddr(vlg_waddr), .wdata(vlg_wdata),
        .raddr(vlg_raddr), .rhit(vlg_rhit), .rdata(vlg_hdata),
        .xaddr(ila_addr), .xhit(vlg_xhit), .xdata(vlg_xdata),
        .ent_valid(vlg_valid), .ent_addr(vlg_addr), .ent_data(vlg_data),
        .cnt(vlg_cnt), .full(vlg_full), .whit(vlg_whit)
    );

    absmem_wlog #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW)) u_ila (
        .clk(clk), .rst_n(rst_n),
        .wen(ila_wen_real), .waddr(ila_waddr), .wdata(ila_wdata),
        .raddr(ila_raddr), .rhit(ila_rhit), .rdata(ila_hdata),
        .xaddr(vlg_addr), .xhit(ila_xhit), .xdata(ila_xdata),
        .ent_valid(ila_valid), .ent_addr(ila_addr), .ent_data(ila_data),
        .cnt(ila_cnt), .full(ila_full), .whit(ila_whit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            armed_q    <= armed_q | issue;
            overflow_q <= overflow_q
                        | (vlg_wen_real & vlg_full & ~vlg_whit)
                        | (ila_wen_real & ila_full & ~ila_whit);
        end
    end

    assign overflow  = overflow_q;
    assign vlg_rdata = vlg_ren_real ? (vlg_rhit ? vlg_hdata : mem[vlg_raddr]) : vlg_r_rand_input;
    assign ila_rdata = ila_ren_real ? (ila_rhit ? ila_hdata : mem[ila_raddr]) : ila_r_rand_input;

    // An entry absent from the other log must match the untouched base value.
    logic [DEPTH-1:0] vlg_ok_vec, ila_ok_vec;
    for (genvar i = 0; i < DEPTH; i++) begin : g_eq
        assign vlg_ok_vec[i] = ~vlg_valid[i] |
                               (ila_xhit[i] ? (ila_xdata[i] == vlg_data[i])
                                            : (vlg_data[i] == mem[vlg_addr[i]]));
        assign ila_ok_vec[i] = ~ila_valid[i] |
                               (vlg_xhit[i] ? (vlg_xdata[i] == ila_data[i])
                                            : (ila_data[i] == mem[ila_addr[i]]));
    end

    assign equal = compare & ~overflow_q & (&vlg_ok_vec) & (&ila_ok_vec);

endmodule

// File: tb/tb_absmem_wlog_multi.sv
// tb/tb_absmem_wlog_multi.sv - directed and randomized checks against a map-based memory model
module tb_absmem_wlog_multi;
    localparam int AW = 8, DW = 8, TTS = 256, DEPTH = 4, CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0, issue = 1'b0, compare = 1'b0;
    logic [AW-1:0] vlg_raddr = '0, vlg_waddr = '0, ila_raddr = '0, ila_waddr = '0;
    logic [DW-1:0] vlg_wdata = '0, ila_wdata = '0, vlg_r_rand_input = '0, ila_r_rand_input = '0;
    logic          vlg_ren = 1'b0, vlg_wen = 1'b0, ila_ren = 1'b0, ila_wen = 1'b0;
    logic [DW-1:0] vlg_rdata, ila_rdata;
    logic          equal, overflow;
    logic [CW-1:0] vlg_cnt, ila_cnt;

    absmem_wlog_multi #(.AW(AW), .DW(DW), .TTS(TTS), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .issue(issue), .compare(compare),
        .vlg_raddr(vlg_raddr), .vlg_ren(vlg_ren), .vlg_rdata(vlg_rdata),
        .vlg_waddr(vlg_waddr), .vlg_wdata(vlg_wdata), .vlg_wen(vlg_wen),
        .vlg_r_rand_input(vlg_r_rand_input),
        .ila_raddr(ila_raddr), .ila_ren(ila_ren), .ila_rdata(ila_rdata),
        .ila_waddr(ila_waddr), .ila_wdata(ila_wdata), .ila_wen(ila_wen),
        .ila_r_rand_input(ila_r_rand_input),
        .equal(equal), .overflow(overflow), .vlg_cnt(vlg_cnt), .ila_cnt(ila_cnt)
    );

    int errors = 0, checks = 0;

    // Reference model: each log is an address->data map, base values are learned once.
    int unsigned vm[int];
    int unsigned im[int];
    int unsigned base[256];
    bit m_armed = 0, m_ovf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_equal();
        bit ok = compare && !m_ovf;
        foreach (vm[a]) ok &= im.exists(a) ? (im[a] == vm[a]) : (vm[a] == base[a]);
        foreach (im[a]) ok &= vm.exists(a) ? (vm[a] == im[a]) : (im[a] == base[a]);
        return ok;
    endfunction

    task automatic model_write(inout int unsigned m[int], input int a, input int unsigned d);
        if (m.exists(a)) m[a] = d;
        else if (m.num() < DEPTH) m[a] = d;
        else m_ovf = 1;
    endtask

    function automatic int unsigned model_read(input int unsigned m[int], input bit ren,
                                               input int a, input int unsigned r);
        if (!(ren && m_armed && !compare)) return r;
        return m.exists(a) ? m[a] : base[a];
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".vlg_cnt"}, 32'(vlg_cnt), 32'(vm.num()));
        chk({tag, ".ila_cnt"}, 32'(ila_cnt), 32'(im.num()));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".equal"}, 32'(equal), 32'(model_equal()));
    endtask

    // One cycle: optional writes and reads on both sides; reads are checked before the edge.
    task automatic step(input string tag,
                        input bit vw, input int va, input int unsigned vd,
                        input bit iw, input int ia, input int unsigned id,
                        input bit vr, input int vra, input bit ir, input int ira);
        int unsigned vrnd = $urandom_range(255), irnd = $urandom_range(255);
        vlg_wen = vw; vlg_waddr = AW'(va); vlg_wdata = DW'(vd);
        ila_wen = iw; ila_waddr = AW'(ia); ila_wdata = DW'(id);
        vlg_ren = vr; vlg_raddr = AW'(vra); vlg_r_rand_input = DW'(vrnd);
        ila_ren = ir; ila_raddr = AW'(ira); ila_r_rand_input = DW'(irnd);
        #1;
        chk({tag, ".vlg_rdata"}, 32'(vlg_rdata), model_read(vm, vr, vra, vrnd));
        chk({tag, ".ila_rdata"}, 32'(ila_rdata), model_read(im, ir, ira, irnd));
        cyc();
        if (m_armed && !compare) begin
            if (vw) model_write(vm, va, vd);
            if (iw) model_write(im, ia, id);
        end
        vlg_wen = 0; ila_wen = 0; vlg_ren = 0; ila_ren = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; issue = 0; compare = 0;
        vm.delete(); im.delete(); m_armed = 0; m_ovf = 0;
        #3;
        cyc();
        rst_n = 1;
    endtask

    task automatic arm();
        issue = 1;
        cyc();
        issue = 0;
        m_armed = 1;
    endtask

    initial begin
        int a, nops;
        int unsigned d;

        do_reset();
        check_state("reset");
        // Before issue: reads return the free input and writes are dropped.
        step("pre_issue", 1, 8'h30, 8'h11, 1, 8'h30, 8'h22, 1, 8'h30, 1, 8'h31);
        vlg_ren = 1; vlg_r_rand_input = 8'h5C; #1;
        chk("pre_issue.rand5c", 32'(vlg_rdata), 32'h5C);
        vlg_ren = 0;
        check_state("pre_issue");

        arm();
        // Learn the symbolic base contents through reads on an empty log.
        vlg_ren = 1;
        for (int i = 0; i < 256; i++) begin
            vlg_raddr = AW'(i); #1;
            base[i] = 32'(vlg_rdata);
        end
        vlg_ren = 0;

        step("t1", 1, 8'h10, 8'hAA, 1, 8'h10, 8'hAA, 0, 0, 0, 0);
        compare = 1; #1; check_state("t1_cmp"); compare = 0;

        do_reset(); arm();
        step("t2a", 1, 8'h10, 8'hAA, 0, 0, 0, 0, 0, 0, 0);
        step("t2b", 1, 8'h10, 8'hBB, 1, 8'h10, 8'hBB, 1, 8'h10, 0, 0);
        step("t2c", 0, 0, 0, 0, 0, 0, 1, 8'h10, 1, 8'h10);
        chk("t2.fwd", 32'(vlg_cnt), 32'd1);
        compare = 1; #1; check_state("t2_cmp"); compare = 0;

        do_reset(); arm();
        step("t3a", 1, 8'h20, base[8'h20], 0, 0, 0, 0, 0, 1, 8'h20);
        compare = 1; #1; check_state("t3a_cmp"); chk("t3a.equal1", 32'(equal), 32'd1); compare = 0;
        do_reset(); arm();
        step("t3b", 1, 8'h20, base[8'h20] ^ 1, 0, 0, 0, 0, 0, 0, 0);
        compare = 1; #1; check_state("t3b_cmp"); chk("t3b.equal0", 32'(equal), 32'd0); compare = 0;

        do_reset(); arm();
        for (int i = 0; i < 5; i++) step("t4", 1, i, base[i], 1, i, base[i], 0, 0, 0, 0);
        compare = 1; #1; check_state("t4_cmp");
        chk("t4.overflow", 32'(overflow), 32'd1);
        // Compare window: writes ignored, reads return the free input.
        step("t5_cmp", 1, 8'h40, 8'h01, 1, 8'h41, 8'h02, 1, 8'h00, 1, 8'h01);
        check_state("t5_cmp");
        compare = 0;

        do_reset(); arm();
        for (int i = 0; i < 3; i++) step("t6", 1, 8'h50 + i, 8'h77, 0, 0, 0, 0, 0, 0, 0);
        chk("t6.cnt3", 32'(vlg_cnt), 32'd3);
        @(negedge clk);
        rst_n = 0; vlg_ren = 1; vlg_raddr = 8'h50; vlg_r_rand_input = 8'h3C;
        #1;
        chk("t6.async_cnt", 32'(vlg_cnt), 32'd0);
        chk("t6.async_ovf", 32'(overflow), 32'd0);
        chk("t6.async_rdata", 32'(vlg_rdata), 32'h3C);
        vlg_ren = 0;

        for (int r = 0; r < 12; r++) begin
            do_reset(); arm();
            nops = 3 + $urandom_range(6);
            for (int k = 0; k < nops; k++) begin
                a = $urandom_range(5);
                d = ($urandom_range(3) == 0) ? 32'hAA : base[a];
                step("rnd", $urandom_range(1) == 1, a, d,
                     $urandom_range(1) == 1, $urandom_range(5),
                     ($urandom_range(1) == 1) ? base[a] : d,
                     $urandom_range(1) == 1, $urandom_range(5),
                     $urandom_range(1) == 1, $urandom_range(5));
                if ($urandom_range(1) == 1) step("rnd_issue_again", 0, 0, 0, 0, 0, 0, 1, a, 1, a);
            end
            check_state("rnd_pre");
            compare = 1; #1; check_state("rnd_cmp");
            step("rnd_cmpw", 1, 7, 8'h99, 1, 7, 8'h98, 1, 7, 1, 3);
            check_state("rnd_cmp_hold");
            compare = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
